// File: rtl/mem_arbiter_if.sv
// Shared fetch/data/RAM signal bundle for mem_arbiter.
// The slave modport is the arbiter; master is the requesters plus the RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_w_en;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
           ram_addr, ram_wdata, ram_w_en
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
           ram_addr, ram_wdata, ram_w_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one single-port RAM: unbuffered, round-robin on
// conflict, with a read-tag pipeline that routes returning data to its port.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_DATA} tag_e;
  typedef enum logic {WIN_FETCH, WIN_DATA} win_e;

  win_e              last_winner_q, last_winner_d;
  tag_e              tag_q [RD_LAT];
  tag_e              tag_d [RD_LAT];
  logic              grant_f, grant_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [31:0]       ram_wdata_d;
  logic              ram_w_en_d;

  // Grants are gated by rst_n so the bus reads idle during reset even
  // while requesters keep their requests asserted.
  always_comb begin
    grant_f       = 1'b0;
    grant_d       = 1'b0;
    last_winner_d = last_winner_q;
    if (rst_n) begin
      if (bus.if_req && bus.d_req) begin
        if (last_winner_q == WIN_FETCH) begin
          grant_d       = 1'b1;
          last_winner_d = WIN_DATA;
        end else begin
          grant_f       = 1'b1;
          last_winner_d = WIN_FETCH;
        end
      end else begin
        grant_f = bus.if_req;
        grant_d = bus.d_req;
      end
    end
  end

  always_comb begin
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ram_w_en_d  = 1'b0;
    if (grant_d) begin
      ram_addr_d  = bus.d_addr;
      ram_wdata_d = bus.d_wdata;
      ram_w_en_d  = bus.d_we;
    end else if (grant_f) begin
      ram_addr_d  = bus.if_addr;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      tag_d[i] = TAG_NONE;
    end
    if (grant_f) begin
      tag_d[0] = TAG_FETCH;
    end else if (grant_d && !bus.d_we) begin
      tag_d[0] = TAG_DATA;
    end
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= WIN_FETCH;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= TAG_NONE;
      end
    end else begin
      last_winner_q <= last_winner_d;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign bus.if_ack    = grant_f;
  assign bus.d_ack     = grant_d;
  assign bus.ram_addr  = ram_addr_d;
  assign bus.ram_wdata = ram_wdata_d;
  assign bus.ram_w_en  = ram_w_en_d;

  // Both ports see the raw RAM data; the rvalid strobes say whose it is.
  assign bus.if_rvalid = (tag_q[RD_LAT-1] == TAG_FETCH);
  assign bus.d_rvalid  = (tag_q[RD_LAT-1] == TAG_DATA);
  assign bus.if_rdata  = bus.ram_rdata;
  assign bus.d_rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RD_LAT=1 and RD_LAT=3 instances share one stimulus
// stream and are checked against a cycle-stamped scoreboard every cycle.
module tb_mem_arbiter;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;

  mem_arbiter_if #(.ADDR_W(AW)) bus1 ();
  mem_arbiter_if #(.ADDR_W(AW)) bus3 ();

  assign bus1.if_req  = if_req;  assign bus3.if_req  = if_req;
  assign bus1.if_addr = if_addr; assign bus3.if_addr = if_addr;
  assign bus1.d_req   = d_req;   assign bus3.d_req   = d_req;
  assign bus1.d_we    = d_we;    assign bus3.d_we    = d_we;
  assign bus1.d_addr  = d_addr;  assign bus3.d_addr  = d_addr;
  assign bus1.d_wdata = d_wdata; assign bus3.d_wdata = d_wdata;

  mem_arbiter #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mem_arbiter #(.ADDR_W(AW), .RD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // RAM models: data captured at the address cycle, delivered RD_LAT later.
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] dp1;
  logic [31:0] dp3 [3];
  always @(posedge clk) begin
    if (bus1.ram_w_en) ram_mem[bus1.ram_addr] <= bus1.ram_wdata;
    dp1    <= ram_mem[bus1.ram_addr];
    dp3[0] <= ram_mem[bus3.ram_addr];
    dp3[1] <= dp3[0];
    dp3[2] <= dp3[1];
  end
  assign bus1.ram_rdata = dp1;
  assign bus3.ram_rdata = dp3[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: each accepted read becomes {cycle it must return, port, data}.
  typedef struct {
    int          due;
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] ref_mem [DEPTH];
  bit          data_next = 1'b1;
  int          cyc = 0;
  bit          gf, gd, ef, ed;
  logic [31:0] edat;
  logic [31:0] exp_addr;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      q3.delete();
      data_next = 1'b1;
      gf = 1'b0;
      gd = 1'b0;
    end else if (if_req && d_req) begin
      gd = data_next;
      gf = !data_next;
      data_next = !data_next;
    end else begin
      gf = if_req;
      gd = d_req;
    end

    exp_addr = gd ? 32'(d_addr) : (gf ? 32'(if_addr) : 32'd0);
    chk("if_ack1", bus1.if_ack, gf);
    chk("d_ack1", bus1.d_ack, gd);
    chk("if_ack3", bus3.if_ack, gf);
    chk("d_ack3", bus3.d_ack, gd);
    chk("ram_addr1", bus1.ram_addr, exp_addr);
    chk("ram_addr3", bus3.ram_addr, exp_addr);
    chk("ram_w_en1", bus1.ram_w_en, gd && d_we);
    chk("ram_w_en3", bus3.ram_w_en, gd && d_we);
    if (!gf) begin
      chk("ram_wdata1", bus1.ram_wdata, gd ? d_wdata : 32'd0);
      chk("ram_wdata3", bus3.ram_wdata, gd ? d_wdata : 32'd0);
    end

    ef = 1'b0; ed = 1'b0; edat = '0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      ef = !e.is_d; ed = e.is_d; edat = e.data;
    end
    chk("if_rvalid1", bus1.if_rvalid, ef);
    chk("d_rvalid1", bus1.d_rvalid, ed);
    if (ef) chk("if_rdata1", bus1.if_rdata, edat);
    if (ed) chk("d_rdata1", bus1.d_rdata, edat);

    ef = 1'b0; ed = 1'b0; edat = '0;
    if (q3.size() > 0 && q3[0].due == cyc) begin
      e = q3.pop_front();
      ef = !e.is_d; ed = e.is_d; edat = e.data;
    end
    chk("if_rvalid3", bus3.if_rvalid, ef);
    chk("d_rvalid3", bus3.d_rvalid, ed);
    if (ef) chk("if_rdata3", bus3.if_rdata, edat);
    if (ed) chk("d_rdata3", bus3.d_rdata, edat);

    if (gf) begin
      q1.push_back('{cyc + 1, 1'b0, ref_mem[if_addr]});
      q3.push_back('{cyc + 3, 1'b0, ref_mem[if_addr]});
    end else if (gd && !d_we) begin
      q1.push_back('{cyc + 1, 1'b1, ref_mem[d_addr]});
      q3.push_back('{cyc + 3, 1'b1, ref_mem[d_addr]});
    end else if (gd && d_we) begin
      ref_mem[d_addr] = d_wdata;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit fr, input logic [AW-1:0] fa, input bit dr, input bit dw,
                    input logic [AW-1:0] da, input logic [31:0] dd);
    step();
    if_req = fr; if_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  logic [3:0] grants, rvs;
  bit         ia, da_s;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram_mem[i] = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    ram_mem[5]     = 32'hE3A01001; ref_mem[5]     = 32'hE3A01001;
    ram_mem[11'h10] = 32'h11110010; ref_mem[11'h10] = 32'h11110010;
    ram_mem[11'h11] = 32'h22220011; ref_mem[11'h11] = 32'h22220011;
    ram_mem[11'h12] = 32'h33330012; ref_mem[11'h12] = 32'h33330012;

    repeat (3) step();
    @(negedge clk);
    chk("rst_if_ack", bus1.if_ack, 0);
    chk("rst_ram_addr", bus1.ram_addr, 0);
    step();
    rst_n = 1'b1;

    // Single fetch at RD_LAT=1.
    go(1, 11'd5, 0, 0, '0, '0);
    @(negedge clk);
    chk("f5_ack", bus1.if_ack, 1);
    go(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("f5_rvalid", bus1.if_rvalid, 1);
    chk("f5_rdata", bus1.if_rdata, 32'hE3A01001);

    // Store then load of the same word.
    go(0, '0, 1, 1, 11'd9, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_wen", bus1.ram_w_en, 1);
    go(0, '0, 1, 0, 11'd9, '0);
    @(negedge clk);
    chk("ld_wen", bus1.ram_w_en, 0);
    chk("ld_ack", bus1.d_ack, 1);
    go(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("ld_rvalid", bus1.d_rvalid, 1);
    chk("ld_rdata", bus1.d_rdata, 32'hDEADBEEF);
    chk("ld_if_rvalid", bus1.if_rvalid, 0);

    // RD_LAT=3 pipelined reads F,D,F.
    go(1, 11'h10, 0, 0, '0, '0);
    go(0, '0, 1, 0, 11'h11, '0);
    go(1, 11'h12, 0, 0, '0, '0);
    go(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("l3_rv0", {bus3.if_rvalid, bus3.d_rvalid}, 2'b10);
    chk("l3_rd0", bus3.if_rdata, 32'h11110010);
    step();
    @(negedge clk);
    chk("l3_rv1", {bus3.if_rvalid, bus3.d_rvalid}, 2'b01);
    chk("l3_rd1", bus3.d_rdata, 32'h22220011);
    step();
    @(negedge clk);
    chk("l3_rv2", {bus3.if_rvalid, bus3.d_rvalid}, 2'b10);
    chk("l3_rd2", bus3.if_rdata, 32'h33330012);

    // Reset mid-flight: asynchronous clear, no stale rvalid after release.
    go(1, 11'h20, 0, 0, '0, '0);
    go(0, '0, 1, 0, 11'h21, '0);
    go(1, 11'h22, 1, 0, 11'h23, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_if_ack", bus1.if_ack, 0);
    chk("ar_d_ack", bus1.d_ack, 0);
    chk("ar_d_rvalid", bus1.d_rvalid, 0);
    chk("ar_ram_addr", bus1.ram_addr, 0);
    go(0, '0, 0, 0, '0, '0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ar_no_rv", {bus1.if_rvalid, bus1.d_rvalid, bus3.if_rvalid, bus3.d_rvalid}, 0);
      step();
    end

    // Sustained conflict after reset: data first, then alternating.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) go(1, 11'h30, 1, 0, 11'h31, '0);
      else       go(0, '0, 0, 0, '0, '0);
      @(negedge clk);
      if (k < 4) grants[3-k] = bus1.d_ack;
      if (k > 0) rvs[4-k] = bus1.d_rvalid;
    end
    chk("cf_grants", grants, 4'b1010);
    chk("cf_rv_tags", rvs, 4'b1010);

    // Random traffic; requests held stable until acknowledged.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      ia = bus1.if_ack;
      da_s = bus1.d_ack;
      step();
      if (!if_req || ia) begin
        if_req  = ($urandom_range(0, 99) < 55);
        if_addr = AW'($urandom_range(0, 63));
      end
      if (!d_req || da_s) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = AW'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
    end
    go(0, '0, 0, 0, '0, '0);
    repeat (6) step();
    @(negedge clk);
    chk("drain", q1.size() + q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the word-address width of all address ports.
REQ-002 Parameter RD_LAT, default 1, legal range 1..3, SHALL set the RAM read latency in cycles (address cycle to data cycle).
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 if_req  in  1  SHALL be the instruction-fetch read request.
REQ-006 if_addr  in  ADDR_W  SHALL be the fetch word address.
REQ-007 if_ack  out  1  SHALL indicate the fetch request is accepted this cycle.
REQ-008 if_rvalid  out  1  SHALL indicate fetch read data is valid on if_rdata.
REQ-009 if_rdata  out  32  SHALL be the fetch read data.
REQ-010 d_req  in  1  SHALL be the data-port (load/store) request.
REQ-011 d_we  in  1  SHALL select write (1) or read (0) for d_req.
REQ-012 d_addr  in  ADDR_W  SHALL be the data word address.
REQ-013 d_wdata  in  32  SHALL be the store data.
REQ-014 d_ack  out  1  SHALL indicate the data request is accepted this cycle.
REQ-015 d_rvalid  out  1  SHALL indicate load data is valid on d_rdata.
REQ-016 d_rdata  out  32  SHALL be the load data.
REQ-017 ram_addr  out  ADDR_W  SHALL be the single-port RAM address.
REQ-018 ram_wdata  out  32  SHALL be the RAM write data.
REQ-019 ram_w_en  out  1  SHALL be the RAM write enable.
REQ-020 ram_rdata  in  32  SHALL be the RAM read data, valid RD_LAT cycles after its address cycle.

Function
REQ-021 At most one of if_ack/d_ack SHALL be high in any cycle; ack SHALL be combinational from the current-cycle requests and the last_winner register.
REQ-022 Only if_req high: if_ack=1; ram_addr=if_addr, ram_w_en=0.
REQ-023 Only d_req high: d_ack=1; ram_addr=d_addr, ram_wdata=d_wdata, ram_w_en=d_we.
REQ-024 Both high (conflict): grant to the port that did NOT win the previous conflict; last_winner SHALL update only on conflict cycles.
REQ-025 No request: both acks 0, ram_w_en=0, ram_addr=0, ram_wdata=0.
REQ-026 ram_w_en SHALL never be high unless d_ack and d_we are both high that cycle.
REQ-027 A requester SHALL hold req, addr, we and wdata stable until acked; the arbiter SHALL NOT buffer requests (no queue).
REQ-028 Each accepted read SHALL push a tag (FETCH, DATA) into an RD_LAT-deep shift pipeline; accepted writes and idle cycles SHALL push NONE.
REQ-029 The tag leaving the pipeline SHALL assert exactly the matching rvalid for one cycle, exactly RD_LAT cycles after the ack cycle.
REQ-030 if_rdata and d_rdata SHALL both be driven with ram_rdata combinationally; consumers SHALL qualify with rvalid.
REQ-031 Back-to-back accepted reads SHALL yield back-to-back rvalids in acceptance order; throughput one access per cycle.
REQ-032 A read immediately following a write to the same address SHALL return the newly written data (RAM write-first ordering is not relied upon because accesses are serialized by cycle).

Reset
REQ-033 While rst_n=0: if_ack=d_ack=0, if_rvalid=d_rvalid=0, ram_w_en=0, ram_addr=0, ram_wdata=0, tag pipeline all NONE, last_winner=FETCH (data wins first conflict).
REQ-034 Reads in flight when rst_n asserts SHALL be discarded; no rvalid SHALL appear after reset release for them.
REQ-035 Reset assertion SHALL take effect without a clock edge; release SHALL be sampled on the next rising edge.

Verification
REQ-036 RD_LAT=1, if_req only, if_addr=5, RAM[5]=0xE3A01001 -> if_ack same cycle, if_rvalid one cycle later, if_rdata=0xE3A01001.
REQ-037 d_req, d_we=1, d_addr=9, d_wdata=0xDEADBEEF, then d_req read addr 9 -> ram_w_en pulse one cycle, then d_rvalid with d_rdata=0xDEADBEEF, if_rvalid stays 0.
REQ-038 if_req and d_req held high 4 cycles after reset -> grants alternate D,F,D,F; rvalids follow with matching tags.
REQ-039 RD_LAT=3, reads F@0x10, D@0x11, F@0x12 on consecutive cycles -> if_rvalid, d_rvalid, if_rvalid on cycles 3,4,5 with correct data.
REQ-040 Two reads accepted, rst_n pulsed low mid-flight -> all outputs 0 immediately, no rvalid after release, next conflict granted to data.
REQ-041 Random requests 10k cycles -> never both acks, ram_w_en only with d_ack&d_we, every accepted read gets exactly one rvalid at RD_LAT.
